// File: rtl/helios_link_pkg.sv
// Shared link definitions for the leaf ingress path: flit geometry, source tags, arbiter states.
package helios_link_pkg;
  localparam int DEF_FLIT_WIDTH = 64;
  localparam int LAST_BIT       = DEF_FLIT_WIDTH - 1;
  localparam int NUM_SRC        = 3;

  typedef enum logic [1:0] {
    SRC_PARENT = 2'd0,
    SRC_GRID_1 = 2'd1,
    SRC_GRID_2 = 2'd2
  } src_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // (base + off) mod NUM_SRC, for offsets 0..2
  function automatic src_t src_add(input src_t base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return src_t'(s[1:0]);
  endfunction
endpackage

// File: rtl/leaf_rx_fifo.sv
// Per-input synchronous FIFO; ready comes only from registered state so there is
// no combinational path from the upstream valid or the downstream side.
module leaf_rx_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  input  logic             pop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             live;
  logic             push;

  // live holds ready low through reset and rises on the first edge after release
  assign in_ready  = live && (count != (AW+1)'(DEPTH));
  assign push      = in_valid && in_ready;
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      live <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end
endmodule

// File: rtl/leaf_rx_merge_arbiter.sv
// Leaf ingress merge: three buffered inputs, round-robin arbitration that locks onto a
// source until its LAST flit, registered source-tagged output and saturating flit counters.
module leaf_rx_merge_arbiter
  import helios_link_pkg::*;
#(
  parameter int FLIT_WIDTH = DEF_FLIT_WIDTH,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [FLIT_WIDTH-1:0]        parent_in_data,
  input  logic                         parent_in_valid,
  output logic                         parent_in_ready,
  input  logic [FLIT_WIDTH-1:0]        grid_1_in_data,
  input  logic                         grid_1_in_valid,
  output logic                         grid_1_in_ready,
  input  logic [FLIT_WIDTH-1:0]        grid_2_in_data,
  input  logic                         grid_2_in_valid,
  output logic                         grid_2_in_ready,
  output logic [FLIT_WIDTH-1:0]        out_data,
  output logic [1:0]                   out_src,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_SRC*CNT_WIDTH-1:0] flit_count
);
  localparam int LAST = FLIT_WIDTH - 1;

  logic [NUM_SRC-1:0][FLIT_WIDTH-1:0] in_data, head_data;
  logic [NUM_SRC-1:0]                 in_valid, in_ready, fifo_empty, pop;

  arb_state_t state, state_nxt;
  src_t       rr_ptr, rr_nxt, lock_ch, lock_nxt, gnt_ch;
  logic       gnt_vld, gnt_last, load_ok, do_pop;

  assign in_data  = {grid_2_in_data, grid_1_in_data, parent_in_data};
  assign in_valid = {grid_2_in_valid, grid_1_in_valid, parent_in_valid};
  assign parent_in_ready = in_ready[SRC_PARENT];
  assign grid_1_in_ready = in_ready[SRC_GRID_1];
  assign grid_2_in_ready = in_ready[SRC_GRID_2];

  generate
    for (genvar ch = 0; ch < NUM_SRC; ch++) begin : g_ch
      logic [CNT_WIDTH-1:0] cnt_q;

      leaf_rx_fifo #(.WIDTH(FLIT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .in_data   (in_data[ch]),
        .in_valid  (in_valid[ch]),
        .in_ready  (in_ready[ch]),
        .head_data (head_data[ch]),
        .empty     (fifo_empty[ch]),
        .pop       (pop[ch])
      );

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          cnt_q <= '0;
        else if (in_valid[ch] && in_ready[ch] && cnt_q != '1)
          cnt_q <= cnt_q + CNT_WIDTH'(1);
      end

      assign flit_count[ch*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ARB_IDLE;
      rr_ptr  <= SRC_PARENT;
      lock_ch <= SRC_PARENT;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_nxt;
      lock_ch <= lock_nxt;
    end
  end

  // rr_ptr only moves on IDLE grants; a locked message never rotates priority
  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_ch;
    rr_nxt    = rr_ptr;
    if (do_pop) begin
      if (state == ARB_IDLE) begin
        rr_nxt = src_add(gnt_ch, 2'd1);
        if (!gnt_last) begin
          state_nxt = ARB_LOCKED;
          lock_nxt  = gnt_ch;
        end
      end else if (gnt_last) begin
        state_nxt = ARB_IDLE;
      end
    end
  end

  // Scan from the farthest offset down so the nearest non-empty source wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = rr_ptr;
    if (state == ARB_LOCKED) begin
      gnt_vld = !fifo_empty[lock_ch];
      gnt_ch  = lock_ch;
    end else begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (!fifo_empty[src_add(rr_ptr, 2'(i))]) begin
          gnt_vld = 1'b1;
          gnt_ch  = src_add(rr_ptr, 2'(i));
        end
      end
    end
    pop         = '0;
    pop[gnt_ch] = do_pop;
  end

  assign load_ok  = !out_valid || out_ready;
  assign do_pop   = load_ok && gnt_vld;
  assign gnt_last = head_data[gnt_ch][LAST];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
    end else if (load_ok) begin
      out_valid <= do_pop;
      if (do_pop) begin
        out_data <= head_data[gnt_ch];
        out_src  <= gnt_ch;
      end
    end
  end
endmodule
